// File: rtl/tls_pkg.sv
// Shared types and constants for the traffic-light request controller.
// Provides the FSM state enum, config address map and duration helpers.
package tls_pkg;

    localparam int DUR_W = 4;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SET_P,
        ST_JUMP_P,
        ST_COOL
    } state_t;

    localparam logic [1:0] ADDR_G = 2'd0;
    localparam logic [1:0] ADDR_Y = 2'd1;
    localparam logic [1:0] ADDR_R = 2'd2;

    // A duration set is loadable only if no phase would be zero length.
    function automatic logic dur_ok(
        input logic [DUR_W-1:0] g,
        input logic [DUR_W-1:0] y,
        input logic [DUR_W-1:0] r
    );
        return (g != '0) && (y != '0) && (r != '0);
    endfunction

endpackage

// File: rtl/tls_btn_debounce.sv
// Button conditioner: 2-flop sync, stability debounce, rising-edge detect.
// Ports: clk, reset (async high), btn (raw), press (1-cycle pulse).
module tls_btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic          last;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;
    logic          stable;

    assign stable = (s2 == last);
    assign press  = level & ~level_q;

    // cnt counts cycles the synced level has matched its previous value;
    // when it reaches DEB_CYCLES-2 the level has been seen DEB_CYCLES times.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            last    <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            s1      <= btn;
            s2      <= s1;
            last    <= s2;
            level_q <= level;
            if (!stable)
                cnt <= '0;
            else if (cnt != CW'(DEB_CYCLES - 1))
                cnt <= cnt + CW'(1);
            if (stable && cnt == CW'(DEB_CYCLES - 2))
                level <= s2;
        end
    end

endmodule

// File: rtl/tls_request_ctrl.sv
// Command stage ahead of the light sequencer: owns G/Y/R durations and
// turns config commits, pedestrian/emergency/maintenance inputs into
// Set/Jump/Stop. Inputs: cfg_*, ped_btn, emg_req, maint_hold, Gout/Yout/Rout.
// Outputs: Set, Jump, Stop, Gin/Yin/Rin, ped_ack, cfg_err (all registered).
module tls_request_ctrl
    import tls_pkg::*;
#(
    parameter int               DEB_CYCLES = 4,
    parameter int               MIN_GREEN  = 8,
    parameter int               COOLDOWN   = 16,
    parameter logic [DUR_W-1:0] DEF_G      = 4'd5,
    parameter logic [DUR_W-1:0] DEF_Y      = 4'd2,
    parameter logic [DUR_W-1:0] DEF_R      = 4'd6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [DUR_W-1:0] cfg_wdata,
    input  logic             cfg_commit,
    input  logic             ped_btn,
    input  logic             emg_req,
    input  logic             maint_hold,
    input  logic             Gout,
    input  logic             Yout,
    input  logic             Rout,
    output logic             Set,
    output logic             Jump,
    output logic             Stop,
    output logic [DUR_W-1:0] Gin,
    output logic [DUR_W-1:0] Yin,
    output logic [DUR_W-1:0] Rin,
    output logic             ped_ack,
    output logic             cfg_err
);

    localparam int CCW = $clog2(COOLDOWN + 1);

    state_t           state;
    logic [DUR_W-1:0] stg_g, stg_y, stg_r;
    logic [7:0]       green_cnt;
    logic [CCW-1:0]   cool_cnt;
    logic             emg_s1, emg_sync, emg_d;
    logic             maint_s1, maint_sync;
    logic             ped_press, ped_pending, emg_pend, commit_pend;

    logic stg_ok, emg_rise, emg_want, ped_want, jump_req;
    logic can_set, do_set, do_jump, set_nxt, err_now, ack_now, stop_nxt;

    // Yellow never gates a decision; kept on the port for a symmetric link.
    logic unused_yout;
    assign unused_yout = Yout;

    tls_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ped_deb (
        .clk   (clk),
        .reset (reset),
        .btn   (ped_btn),
        .press (ped_press)
    );

    assign stg_ok   = dur_ok(stg_g, stg_y, stg_r);
    assign emg_rise = emg_sync & ~emg_d;
    assign emg_want = (emg_rise | emg_pend) & ~Rout;
    assign ped_want = ped_pending & Gout & (green_cnt >= 8'(MIN_GREEN));
    assign jump_req = emg_want | ped_want;

    // Commits are served in IDLE and COOL; elsewhere a valid one is parked.
    assign can_set  = (state == ST_IDLE) || (state == ST_COOL);
    assign do_set   = can_set & (cfg_commit | commit_pend) & stg_ok;
    assign do_jump  = (state == ST_IDLE) & jump_req & ~do_set;
    assign set_nxt  = do_set | (state == ST_INIT);
    assign err_now  = ~stg_ok & (cfg_commit | (commit_pend & can_set));
    assign ack_now  = (do_jump & ped_want) | (ped_pending & Rout);
    assign stop_nxt = (maint_sync | (emg_sync & Rout)) & ~set_nxt & ~do_jump;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            emg_s1     <= 1'b0;
            emg_sync   <= 1'b0;
            emg_d      <= 1'b0;
            maint_s1   <= 1'b0;
            maint_sync <= 1'b0;
        end else begin
            emg_s1     <= emg_req;
            emg_sync   <= emg_s1;
            emg_d      <= emg_sync;
            maint_s1   <= maint_hold;
            maint_sync <= maint_s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_INIT;
            stg_g       <= DEF_G;
            stg_y       <= DEF_Y;
            stg_r       <= DEF_R;
            Gin         <= DEF_G;
            Yin         <= DEF_Y;
            Rin         <= DEF_R;
            green_cnt   <= '0;
            cool_cnt    <= '0;
            ped_pending <= 1'b0;
            emg_pend    <= 1'b0;
            commit_pend <= 1'b0;
            Set         <= 1'b0;
            Jump        <= 1'b0;
            Stop        <= 1'b0;
            ped_ack     <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            Set     <= set_nxt;
            Jump    <= do_jump;
            Stop    <= stop_nxt;
            ped_ack <= ack_now;
            cfg_err <= err_now;

            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_G:  stg_g <= cfg_wdata;
                    ADDR_Y:  stg_y <= cfg_wdata;
                    ADDR_R:  stg_r <= cfg_wdata;
                    default: ;
                endcase
            end

            if (do_set) begin
                Gin <= stg_g;
                Yin <= stg_y;
                Rin <= stg_r;
            end

            if (can_set)
                commit_pend <= 1'b0;
            else if (cfg_commit && stg_ok)
                commit_pend <= 1'b1;

            if (!Gout)
                green_cnt <= '0;
            else if (green_cnt != 8'hFF)
                green_cnt <= green_cnt + 8'd1;

            if (ped_press)
                ped_pending <= 1'b1;
            else if (ack_now)
                ped_pending <= 1'b0;

            if (!emg_sync || do_jump)
                emg_pend <= 1'b0;
            else if (emg_rise)
                emg_pend <= 1'b1;

            case (state)
                ST_INIT:   state <= ST_SET_P;
                ST_IDLE: begin
                    if (do_set)
                        state <= ST_SET_P;
                    else if (do_jump)
                        state <= ST_JUMP_P;
                end
                ST_SET_P:  state <= ST_IDLE;
                ST_JUMP_P: begin
                    state    <= ST_COOL;
                    cool_cnt <= CCW'(COOLDOWN - 1);
                end
                ST_COOL: begin
                    if (cool_cnt == '0)
                        state <= ST_IDLE;
                    else
                        cool_cnt <= cool_cnt - CCW'(1);
                end
                default:   state <= ST_INIT;
            endcase
        end
    end

endmodule
